// File: rtl/wb_stage.sv
// Writeback stage: accepts one instruction at a time, aligns and extends load data, and issues one reg_file write.
// Optional WB_RETIRE_CNT_EN adds a free-running 32-bit retired-instruction counter output.
module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  input  logic [1:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_alu_res,
  input  logic [DATA_WIDTH-1:0] Read_data,
  input  logic                  Read_data_Valid,
  output logic                  Read_data_Ready,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic                  rf_wen,
  output logic [DATA_WIDTH-1:0] rf_wdata,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]           retire_cnt,
`endif
  output logic                  retire
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_WAIT  = 3'b010,
    S_WRITE = 3'b100
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  wen_q, wen_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            alo_q, alo_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  // Alignment uses the latched load attributes; Read_data is only sampled in S_WAIT.
  always_comb begin
    ld_byte = Read_data[8*alo_q +: 8];
    ld_half = alo_q[1] ? Read_data[31:16] : Read_data[15:0];
    case (size_q)
      2'b00:   ld_data = {{(DATA_WIDTH-8){~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{(DATA_WIDTH-16){~uns_q & ld_half[15]}}, ld_half};
      default: ld_data = Read_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    size_d  = size_q;
    uns_d   = uns_q;
    alo_d   = alo_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rd_d    = in_rd;
          wen_d   = in_wen;
          size_d  = in_ld_size;
          uns_d   = in_ld_unsigned;
          alo_d   = in_addr_lo;
          res_d   = in_alu_res;
          state_d = in_is_load ? S_WAIT : S_WRITE;
        end
      end
      S_WAIT: begin
        if (Read_data_Valid) begin
          res_d   = ld_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      alo_q   <= 2'b00;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      alo_q   <= alo_d;
      res_q   <= res_d;
    end
  end

  assign in_ready        = (state_q == S_IDLE) && !rst;
  assign Read_data_Ready = (state_q == S_WAIT);
  assign retire          = (state_q == S_WRITE);
  assign rf_wen          = retire && wen_q && (rd_q != '0);
  assign rf_waddr        = rd_q;
  assign rf_wdata        = res_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (retire) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_cnt_q <= '0;
    else     retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
